// File: rtl/mem_io_responder.sv
// Memory-side responder for the CPU byte bus: synchronous RAM, UART tx/rx ports,
// cycle counter with snapshot, and program-stop drain FSM. Optional macro: RESP_ADDR_CHECK_EN.
module mem_io_responder #(
  parameter int unsigned RAM_AW   = 17,
  parameter int unsigned TX_DEPTH = 16
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_stop,
  output logic        bad_access
);

  localparam int unsigned RAM_BYTES = 2 ** RAM_AW;
  localparam int unsigned PTR_W     = $clog2(TX_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [7:0]       r_mem [RAM_BYTES];
  logic [7:0]       r_fifo [TX_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count, w_next_count;
  logic [7:0]       r_mem_din, w_rd_data, w_push_data, r_rx_data;
  logic             r_io_full, r_tx_valid, r_rx_held, r_program_stop, r_bad_access;
  logic [31:0]      r_counter, r_snapshot;

  logic w_io, w_bad_addr, w_wr_en, w_io_en, w_ram_wr, w_tx_wr, w_stop_wr;
  logic w_push_req, w_pop, w_full, w_push, w_overflow;
  logic w_rx_pop, w_rx_accept, w_snap_rd;
  logic w_unused;

  assign w_unused = ^mem_a[31:18];

  // Address decode and qualification of the current bus cycle
  always_comb begin
    w_io = (mem_a[17:16] == 2'b11);
`ifdef RESP_ADDR_CHECK_EN
    w_bad_addr = (mem_a[31:18] != 14'd0) || (mem_a[17:16] == 2'b10);
`else
    w_bad_addr = 1'b0;
`endif
    w_wr_en     = mem_wr && (r_state == ST_RUN) && !w_bad_addr;
    w_io_en     = w_io && (r_state != ST_HALT) && !w_bad_addr;
    w_ram_wr    = w_wr_en && !w_io;
    w_tx_wr     = w_wr_en && w_io && (mem_a[2:0] == 3'b000) && (mem_dout != 8'h00);
    w_stop_wr   = w_wr_en && w_io && (mem_a[2:0] == 3'b100);
    w_push_req  = w_tx_wr || w_stop_wr;
    w_push_data = w_stop_wr ? 8'h00 : mem_dout;
    w_pop       = r_tx_valid && tx_ready;
    w_full      = (r_count == CNT_W'(TX_DEPTH));
    w_push      = w_push_req && (!w_full || w_pop);
    w_overflow  = w_push_req && w_full && !w_pop;
    w_next_count = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    w_rx_pop    = !mem_wr && w_io_en && (mem_a[2:0] == 3'b000);
    w_rx_accept = rx_valid && !r_rx_held;
    w_snap_rd   = !mem_wr && w_io_en && (mem_a[2:0] == 3'b100);
  end

  // Read data mux; a 0x30004 read returns the live counter it is about to snapshot
  always_comb begin
    w_rd_data = 8'h00;
    if (!w_io) begin
      if (!w_bad_addr) w_rd_data = r_mem[mem_a[RAM_AW-1:0]];
    end else if (w_io_en) begin
      case (mem_a[2:0])
        3'b000:  w_rd_data = r_rx_held ? r_rx_data : 8'h00;
        3'b100:  w_rd_data = r_counter[7:0];
        3'b101:  w_rd_data = r_snapshot[15:8];
        3'b110:  w_rd_data = r_snapshot[23:16];
        3'b111:  w_rd_data = r_snapshot[31:24];
        default: w_rd_data = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) r_state <= ST_RUN;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (w_stop_wr) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if ((r_count == '0) && !w_pop) w_state_nxt = ST_HALT;
      ST_HALT:  w_state_nxt = ST_HALT;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (w_ram_wr) r_mem[mem_a[RAM_AW-1:0]] <= mem_dout;
  end

  always_ff @(posedge clk_in) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_mem_din      <= 8'h00;
      r_io_full      <= 1'b0;
      r_tx_valid     <= 1'b0;
      r_count        <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_rx_held      <= 1'b0;
      r_rx_data      <= 8'h00;
      r_counter      <= 32'd0;
      r_snapshot     <= 32'd0;
      r_program_stop <= 1'b0;
      r_bad_access   <= 1'b0;
    end else begin
      if (!mem_wr) r_mem_din <= w_rd_data;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count    <= w_next_count;
      r_tx_valid <= (w_next_count != '0);
      // One slot stays free for the write already in flight when the flag is sampled
      r_io_full  <= (w_next_count >= CNT_W'(TX_DEPTH - 1));
      if (w_rx_accept) begin
        r_rx_data <= rx_data;
        r_rx_held <= 1'b1;
      end else if (w_rx_pop) begin
        r_rx_held <= 1'b0;
      end
      if (r_state != ST_HALT) r_counter <= r_counter + 32'd1;
      if (w_snap_rd) r_snapshot <= r_counter;
      r_program_stop <= (w_state_nxt == ST_HALT);
      r_bad_access   <= r_bad_access | w_overflow | w_bad_addr;
    end
  end

  assign mem_din        = r_mem_din;
  assign io_buffer_full = r_io_full;
  assign tx_data        = r_fifo[r_rd_ptr];
  assign tx_valid       = r_tx_valid;
  assign rx_ready       = ~r_rx_held;
  assign program_stop   = r_program_stop;
  assign bad_access     = r_bad_access;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed-vector bench for mem_io_responder: RAM, tx FIFO, rx holding register,
// counter snapshot, program-stop drain and reset behaviour.
module tb_mem_io_responder;

  localparam logic [31:0] IDLE_A = 32'h0000_1000;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        program_stop;
  logic        bad_access;

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] q_tx[$];

  mem_io_responder dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .mem_a(mem_a), .mem_dout(mem_dout),
    .mem_wr(mem_wr), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .program_stop(program_stop),
    .bad_access(bad_access)
  );

  always #5 clk_in = ~clk_in;

  // Capture every byte the UART side consumes
  always @(posedge clk_in) begin
    if (tx_valid && tx_ready) q_tx.push_back(tx_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic [7:0] d, input logic w);
    mem_a = a; mem_dout = d; mem_wr = w;
    @(posedge clk_in); #1;
    mem_wr = 1'b0; mem_a = IDLE_A; mem_dout = 8'h00;
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    rx_valid = 1'b1; rx_data = d;
    @(posedge clk_in); #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_in); #1; end
  endtask

  int pushes;

  initial begin
    rst_n_in = 1'b0; mem_a = IDLE_A; mem_dout = 8'h00; mem_wr = 1'b0;
    tx_ready = 1'b1; rx_data = 8'h00; rx_valid = 1'b0;
    idle(2);
    rst_n_in = 1'b1;

    chk("rst_mem_din", 32'(mem_din), 0);
    chk("rst_full", 32'(io_buffer_full), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_rx_ready", 32'(rx_ready), 1);
    chk("rst_stop", 32'(program_stop), 0);
    chk("rst_bad", 32'(bad_access), 0);

    // RAM, top address and alias above the RAM range
    bus(32'h0_0010, 8'h5A, 1'b1);
    bus(32'h0_0010, 8'h00, 1'b0);
    chk("ram_raw", 32'(mem_din), 'h5A);
    bus(32'h1_FFFF, 8'hC3, 1'b1);
    bus(32'h1_FFFF, 8'h00, 1'b0);
    chk("ram_top", 32'(mem_din), 'hC3);
    bus(32'h2_0010, 8'h00, 1'b0);
    chk("ram_alias", 32'(mem_din), 'h5A);

    // tx: zero byte dropped
    q_tx.delete();
    bus(32'h3_0000, 8'h48, 1'b1);
    bus(32'h3_0000, 8'h00, 1'b1);
    bus(32'h3_0000, 8'h69, 1'b1);
    idle(5);
    chk("tx_count", 32'(q_tx.size()), 2);
    if (q_tx.size() >= 2) begin
      chk("tx_b0", 32'(q_tx[0]), 'h48);
      chk("tx_b1", 32'(q_tx[1]), 'h69);
    end

    // tx full: gated writes, then the in-flight slot, then an overflow
    tx_ready = 1'b0;
    q_tx.delete();
    pushes = 0;
    for (int i = 0; i < 20; i++) begin
      if (io_buffer_full) break;
      bus(32'h3_0000, 8'(8'h41 + i), 1'b1);
      pushes++;
    end
    chk("full_pushes", 32'(pushes), 15);
    chk("full_flag", 32'(io_buffer_full), 1);
    chk("full_bad0", 32'(bad_access), 0);
    bus(32'h3_0000, 8'h50, 1'b1);
    chk("full_16th_bad", 32'(bad_access), 0);
    bus(32'h3_0000, 8'h51, 1'b1);
    chk("full_17th_bad", 32'(bad_access), 1);
    tx_ready = 1'b1;
    idle(20);
    chk("full_drain_cnt", 32'(q_tx.size()), 16);
    if (q_tx.size() == 16) begin
      chk("full_first", 32'(q_tx[0]), 'h41);
      chk("full_last", 32'(q_tx[15]), 'h50);
    end
    chk("full_flag_clr", 32'(io_buffer_full), 0);

    // rx holding register
    rx_pulse(8'h77);
    chk("rx_held", 32'(rx_ready), 0);
    bus(32'h3_0000, 8'h00, 1'b0);
    chk("rx_pop", 32'(mem_din), 'h77);
    chk("rx_empty", 32'(rx_ready), 1);
    bus(32'h3_0000, 8'h00, 1'b0);
    chk("rx_empty_rd", 32'(mem_din), 0);
    rx_valid = 1'b1; rx_data = 8'h88;
    bus(32'h3_0000, 8'h00, 1'b0);
    rx_valid = 1'b0;
    chk("rx_same_rd", 32'(mem_din), 0);
    chk("rx_same_held", 32'(rx_ready), 0);
    bus(32'h3_0000, 8'h00, 1'b0);
    chk("rx_same_pop", 32'(mem_din), 'h88);

    // program stop with toggling tx_ready
    tx_ready = 1'b0;
    bus(32'h3_0000, 8'h31, 1'b1);
    bus(32'h3_0000, 8'h32, 1'b1);
    bus(32'h3_0000, 8'h33, 1'b1);
    q_tx.delete();
    bus(32'h3_0004, 8'hAA, 1'b1);
    bus(32'h0_0010, 8'hEE, 1'b1);
    chk("stop_pending", 32'(program_stop), 0);
    chk("stop_txv", 32'(tx_valid), 1);
    for (int i = 0; i < 40; i++) begin
      if (!tx_valid) break;
      tx_ready = ~tx_ready;
      @(posedge clk_in); #1;
    end
    chk("stop_drained", 32'(tx_valid), 0);
    chk("stop_not_yet", 32'(program_stop), 0);
    tx_ready = 1'b0;
    idle(1);
    chk("stop_high", 32'(program_stop), 1);
    chk("stop_cnt", 32'(q_tx.size()), 4);
    if (q_tx.size() == 4) begin
      chk("stop_b0", 32'(q_tx[0]), 'h31);
      chk("stop_b2", 32'(q_tx[2]), 'h33);
      chk("stop_b3", 32'(q_tx[3]), 'h00);
    end
    bus(32'h0_0010, 8'h11, 1'b1);
    bus(32'h0_0010, 8'h00, 1'b0);
    chk("halt_ram", 32'(mem_din), 'h5A);
    bus(32'h3_0000, 8'h55, 1'b1);
    chk("halt_io", 32'(tx_valid), 0);

    // counter snapshot 100 cycles after reset, then wrap
    do_reset();
    chk("rst2_stop", 32'(program_stop), 0);
    chk("rst2_bad", 32'(bad_access), 0);
    idle(100);
    bus(32'h3_0004, 8'h00, 1'b0);
    chk("cnt_b0", 32'(mem_din), 'h64);
    bus(32'h3_0005, 8'h00, 1'b0);
    chk("cnt_b1", 32'(mem_din), 0);
    bus(32'h3_0006, 8'h00, 1'b0);
    chk("cnt_b2", 32'(mem_din), 0);
    bus(32'h3_0007, 8'h00, 1'b0);
    chk("cnt_b3", 32'(mem_din), 0);
    force dut.r_counter = 32'hFFFF_FFFE;
    #1;
    release dut.r_counter;
    bus(32'h3_0004, 8'h00, 1'b0);
    chk("wrap_b0", 32'(mem_din), 'hFE);
    bus(32'h3_0005, 8'h00, 1'b0);
    chk("wrap_b1", 32'(mem_din), 'hFF);
    bus(32'h3_0007, 8'h00, 1'b0);
    chk("wrap_b3", 32'(mem_din), 'hFF);
    idle(1);
    bus(32'h3_0004, 8'h00, 1'b0);
    chk("wrap_after_b0", 32'(mem_din), 'h02);
    bus(32'h3_0007, 8'h00, 1'b0);
    chk("wrap_after_b3", 32'(mem_din), 0);

    // reset in the middle of DRAIN
    tx_ready = 1'b0;
    bus(32'h3_0000, 8'h61, 1'b1);
    bus(32'h3_0000, 8'h62, 1'b1);
    rx_pulse(8'h99);
    bus(32'h0_0010, 8'h00, 1'b0);
    chk("t6_pre_rd", 32'(mem_din), 'h5A);
    bus(32'h3_0004, 8'h00, 1'b1);
    chk("t6_pre_txv", 32'(tx_valid), 1);
    @(negedge clk_in);
    rst_n_in = 1'b0;
    #1;
    chk("t6_mem_din", 32'(mem_din), 0);
    chk("t6_full", 32'(io_buffer_full), 0);
    chk("t6_txv", 32'(tx_valid), 0);
    chk("t6_rx_ready", 32'(rx_ready), 1);
    chk("t6_stop", 32'(program_stop), 0);
    chk("t6_bad", 32'(bad_access), 0);
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    bus(32'h0_0010, 8'h00, 1'b0);
    chk("t6_ram_kept", 32'(mem_din), 'h5A);
    chk("t6_fifo_dropped", 32'(tx_valid), 0);
    bus(32'h3_0000, 8'h70, 1'b1);
    chk("t6_run_txv", 32'(tx_valid), 1);
    chk("t6_run_txd", 32'(tx_data), 'h70);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
